// File: rtl/mult_rr_scheduler.sv
`timescale 1ns/1ps
// Round-robin front end sharing one sequential shift-add multiplier among NREQ requesters.
// rsp_valid rises W edges after the accept edge; response is held until rsp_ready and no grant is issued while busy.
module mult_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*W-1:0]      rsp_product,
  input  logic                rsp_ready,
  output logic                busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] tag;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] ptr_next;
  logic [IDW:0]   idx;
  logic           win_vld;
  logic [W-1:0]   a_reg;
  logic [2*W-1:0] p_reg;
  logic [2*W-1:0] p_next;
  logic [W:0]     hi_sum;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   a_arr [NREQ];
  logic [W-1:0]   b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*W +: W];
    assign b_arr[g] = req_b[g*W +: W];
  end

  // Search starts at rr_ptr and wraps; idx never exceeds 2*NREQ-2 so IDW+1 bits suffice.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ))
        idx = idx - (IDW+1)'(NREQ);
      if (!win_vld && req_valid[idx[IDW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = idx[IDW-1:0];
      end
    end
  end

  assign ptr_next  = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
  assign req_ready = (state == S_IDLE && win_vld && !RST) ? (NREQ'(1) << win_id) : '0;
  assign busy      = (state != S_IDLE);

  // Adding A<<W leaves the low half untouched, so only the upper half needs the W+1-bit adder.
  assign hi_sum = {1'b0, p_reg[2*W-1:W]} + {1'b0, a_reg};
  assign p_next = p_reg[0] ? {hi_sum, p_reg[W-1:1]} : (p_reg >> 1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      tag         <= '0;
      a_reg       <= '0;
      p_reg       <= '0;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            a_reg  <= a_arr[win_id];
            p_reg  <= {{W{1'b0}}, b_arr[win_id]};
            tag    <= win_id;
            rr_ptr <= ptr_next;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          p_reg <= p_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(W-1)) begin
            rsp_product <= p_next;
            rsp_id      <= tag;
            rsp_valid   <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
`timescale 1ns/1ps
// Randomised and directed bench for mult_rr_scheduler with a cycle-level round-robin reference model.
module tb_mult_rr_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic                CLK = 1'b0;
  logic                RST;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*W-1:0]   req_a = '0;
  logic [NREQ*W-1:0]   req_b = '0;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [2*W-1:0]      rsp_product;
  logic                rsp_ready = 1'b1;
  logic                busy;

  mult_rr_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct { int id; int a; int b; int at; } op_t;
  typedef struct { int id; int prod; } exp_t;

  op_t  opq[$];
  exp_t sb[$];
  int   g_id[$];
  int   g_cyc[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdy_mode = 0;
  logic [NREQ-1:0] slot_busy = '0;
  logic [NREQ-1:0] acc_mask = '0;

  // Reference model: one operation in flight, response visible W+1 sample cycles after the grant cycle.
  bit m_out = 1'b0;
  int m_ptr = 0;
  int m_acc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic add_op(input int id, input int a, input int b, input int dly);
    op_t o;
    o.id = id; o.a = a; o.b = b; o.at = cyc + dly;
    opq.push_back(o);
  endtask

  // Driver: drops a request after its grant edge and presents the next queued op for that requester.
  initial forever begin
    @(posedge CLK);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_mask[i]) begin
        req_valid[i] = 1'b0;
        slot_busy[i] = 1'b0;
        acc_mask[i]  = 1'b0;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!slot_busy[i]) begin
        for (int j = 0; j < opq.size(); j++) begin
          if (opq[j].id == i && cyc >= opq[j].at) begin
            req_a[i*W +: W] = W'(opq[j].a);
            req_b[i*W +: W] = W'(opq[j].b);
            req_valid[i]    = 1'b1;
            slot_busy[i]    = 1'b1;
            opq.delete(j);
            break;
          end
        end
      end
    end
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Checker: arbitration, busy and response timing against the model; pushes expected responses.
  initial forever begin
    int  w;
    int  ix;
    bit  exp_rv;
    logic [NREQ-1:0] exp_rdy;
    @(negedge CLK);
    cyc++;
    if (RST) begin
      m_out = 1'b0;
      m_ptr = 0;
      sb.delete();
      acc_mask = '0;
    end else begin
      exp_rv = m_out && (cyc >= m_acc + W + 1);
      chk("busy", 32'(busy), 32'(m_out));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      w = -1;
      if (!m_out) begin
        for (int k = 0; k < NREQ; k++) begin
          ix = (m_ptr + k) % NREQ;
          if (w < 0 && req_valid[ix]) w = ix;
        end
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          g_id.push_back(i);
          g_cyc.push_back(cyc);
        end
      end
      if (w >= 0) begin
        exp_t e;
        e.id   = w;
        e.prod = int'(req_a[w*W +: W]) * int'(req_b[w*W +: W]);
        sb.push_back(e);
        m_out = 1'b1;
        m_acc = cyc;
        m_ptr = (w + 1) % NREQ;
        acc_mask[w] = 1'b1;
      end else if (exp_rv && rsp_ready) begin
        m_out = 1'b0;
      end
    end
  end

  // Monitor: every cycle a response is presented it must match the oldest outstanding expectation.
  initial forever begin
    @(negedge CLK);
    if (!RST && rsp_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d product %0d, expected no response", rsp_id, rsp_product);
      end else begin
        chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
        chk("rsp_product", 32'(rsp_product), 32'(sb[0].prod));
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_product", 32'(rsp_product), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    g_id.delete();
    g_cyc.delete();
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((opq.size() != 0 || slot_busy != '0 || m_out || sb.size() != 0) && t < 4000) begin
      @(negedge CLK);
      #1;
      t++;
    end
    chk({nm, "_drain_done"}, 32'(t < 4000), 32'd1);
  endtask

  task automatic chk_grants(input string nm, input int exp_ids[$]);
    chk({nm, "_grant_count"}, 32'(g_id.size()), 32'(exp_ids.size()));
    for (int i = 0; i < exp_ids.size() && i < g_id.size(); i++)
      chk({nm, "_grant_id"}, 32'(g_id[i]), 32'(exp_ids[i]));
  endtask

  initial begin
    int t;
    int ids[$];
    RST = 1'b0;
    #1;
    RST = 1'b1;
    do_reset();

    // Single request on requester 1.
    add_op(1, 12, 10, 0);
    drain("single");
    ids = '{1};
    chk_grants("single", ids);

    // All four valid at once: strict rotation, grants 10 cycles apart.
    do_reset();
    for (int i = 0; i < NREQ; i++) add_op(i, i + 1, 3, 0);
    drain("all4");
    ids = '{0, 1, 2, 3};
    chk_grants("all4", ids);
    for (int i = 1; i < g_cyc.size() && i < 4; i++)
      chk("all4_grant_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(W + 2));

    // Backpressure: response held for 20 cycles while requester 2 waits.
    do_reset();
    rdy_mode = 1;
    add_op(0, 7, 9, 0);
    add_op(2, 5, 5, 3);
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(negedge CLK);
      #1;
      t++;
    end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    repeat (20) @(negedge CLK);
    rdy_mode = 0;
    drain("bp");
    ids = '{0, 2};
    chk_grants("bp", ids);

    // Operand boundaries.
    do_reset();
    add_op(0, 255, 255, 0);
    add_op(1, 0, 200, 0);
    add_op(2, 200, 0, 0);
    add_op(3, 1, 255, 0);
    add_op(0, 128, 2, 0);
    drain("bound");

    // Reset four cycles into a run: the in-flight op vanishes, pointer restarts at 0.
    do_reset();
    add_op(2, 13, 11, 0);
    t = 0;
    while (!m_out && t < 50) begin
      @(negedge CLK);
      #1;
      t++;
    end
    chk("midrst_first_grant", 32'(m_out), 32'd1);
    add_op(3, 9, 9, 0);
    add_op(1, 5, 6, 0);
    while (cyc < m_acc + 4) @(negedge CLK);
    do_reset();
    drain("midrst");
    ids = '{1, 3};
    chk_grants("midrst", ids);

    // Fairness: requester 0 always valid, requester 2 joins after the first grant.
    do_reset();
    for (int i = 0; i < 4; i++) add_op(0, 10 + i, 20 + i, 0);
    for (int i = 0; i < 3; i++) add_op(2, 30 + i, 40 + i, 3);
    drain("fair");
    ids = '{0, 2, 0, 2, 0, 2, 0};
    chk_grants("fair", ids);

    // Random traffic with random response backpressure.
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 60; i++)
      add_op($urandom_range(0, NREQ - 1), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 400));
    drain("rand");
    rdy_mode = 0;

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
